// File: rtl/obi_port_arbiter.sv
// Round-robin arbiter sharing one OBI master port between the CGRA memory nodes.
// In-order in-flight FIFO routes each response back to the node that issued it.

package cgra_pkg;

  localparam int unsigned NODES = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_port_arbiter
  import cgra_pkg::*;
#(
  parameter int unsigned N_MASTERS       = cgra_pkg::NODES,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IDX_W           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  obi_req_t  [N_MASTERS-1:0] masters_req_i,
  output obi_resp_t [N_MASTERS-1:0] masters_resp_o,
  output obi_req_t                  slave_req_o,
  input  obi_resp_t                 slave_resp_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] rr_ptr;
  logic             lock;
  logic [IDX_W-1:0] locked_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head_idx;

  logic             fifo_full;
  logic             fwd_en;
  logic             accept;
  logic             pop;
  logic             any_req;
  logic             err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    winner   = rr_ptr;
    cand_idx = '0;
    found    = 1'b0;
    any_req  = 1'b0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % int'(N_MASTERS));
      if (!found && masters_req_i[cand_idx].req) begin
        winner = cand_idx;
        found  = 1'b1;
      end
      any_req = any_req | masters_req_i[k].req;
    end
    if (lock) begin
      winner = locked_idx;
    end
  end

  // A pop in this cycle does not free a slot: fullness uses the registered count.
  assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
  assign fwd_en    = rst_ni & ~fifo_full;
  assign head_idx  = fifo_mem[rd_ptr];
  assign pop       = slave_resp_i.rvalid & (count != '0);

  always_comb begin
    slave_req_o     = masters_req_i[winner];
    slave_req_o.req = masters_req_i[winner].req & fwd_en;
  end

  assign accept = slave_req_o.req & slave_resp_i.gnt;

  always_comb begin
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      masters_resp_o[i].rdata  = slave_resp_i.rdata;
      masters_resp_o[i].gnt    = accept && (winner == IDX_W'(i));
      masters_resp_o[i].rvalid = pop && (head_idx == IDX_W'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (winner == IDX_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
        lock   <= 1'b0;
        wr_ptr <= ptr_inc(wr_ptr);
      end else if (slave_req_o.req) begin
        // Hold this master until granted; OBI keeps its request stable meanwhile.
        lock       <= 1'b1;
        locked_idx <= winner;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (slave_resp_i.rvalid && (count == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // NOTE: index storage is not reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= winner;
    end
  end

  assign err_o  = err_q;
  assign busy_o = (count != '0) | lock | any_req;

endmodule

// File: tb/tb_obi_port_arbiter.sv
// Directed bench for obi_port_arbiter: four masters, two outstanding slots,
// hand-computed grant/response routing, back-pressure, spurious rvalid and reset.

module tb_obi_port_arbiter;
  import cgra_pkg::*;

  logic             clk_i  = 1'b0;
  logic             rst_ni = 1'b0;
  obi_req_t  [3:0]  masters_req;
  obi_resp_t [3:0]  masters_resp;
  obi_req_t         slave_req;
  obi_resp_t        slave_resp;
  logic             busy;
  logic             err;
  logic      [3:0]  gnt_v;
  logic      [3:0]  rv_v;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

  always #5 clk_i = ~clk_i;

  obi_port_arbiter #(
    .N_MASTERS      (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .masters_req_i (masters_req),
    .masters_resp_o(masters_resp),
    .slave_req_o   (slave_req),
    .slave_resp_i  (slave_resp),
    .busy_o        (busy),
    .err_o         (err)
  );

  for (genvar g = 0; g < 4; g++) begin : g_vec
    assign gnt_v[g] = masters_resp[g].gnt;
    assign rv_v[g]  = masters_resp[g].rvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Master i presents address 0x1000*(i+1)+seq; slave response fields as given.
  task automatic drive(input logic [3:0] reqs, input logic [7:0] seq, input logic gnt,
                       input logic rv, input logic [31:0] rdata);
    for (int i = 0; i < 4; i++) begin
      masters_req[i].req   = reqs[i];
      masters_req[i].we    = 1'b0;
      masters_req[i].be    = 4'hF;
      masters_req[i].addr  = 32'(32'h1000 * (i + 1)) + 32'(seq);
      masters_req[i].wdata = 32'hC0DE_0000 + 32'(i);
    end
    slave_resp.gnt    = gnt;
    slave_resp.rvalid = rv;
    slave_resp.rdata  = rdata;
    #1;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset state
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("rst_gnt", 32'(gnt_v), 32'h0);
    check("rst_rvalid", 32'(rv_v), 32'h0);
    check("rst_slave_req", 32'(slave_req.req), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    rst_ni = 1'b1;

    // 1: single master, back-to-back reads, rvalid one cycle after gnt
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, 8'(k), 1'b1, (k > 0), 32'hD000 + 32'(k) - 32'd1);
      check("t1_gnt", 32'(gnt_v), 32'h1);
      check("t1_addr", slave_req.addr, 32'h1000 + 32'(k));
      if (k > 0) begin
        check("t1_rvalid", 32'(rv_v), 32'h1);
        check("t1_rdata", masters_resp[0].rdata, 32'hD000 + 32'(k) - 32'd1);
      end
      tick();
    end
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'hD003);
    check("t1_last_rvalid", 32'(rv_v), 32'h1);
    check("t1_rdata_bcast", masters_resp[3].rdata, 32'hD003);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    tick();
    do_reset();

    // 2: three masters requesting continuously, round-robin order
    for (int k = 0; k < 6; k++) begin
      drive(4'b0111, 8'(k), 1'b1, (k > 0), 32'hE000 + 32'(k));
      check("t2_gnt", 32'(gnt_v), 32'(exp_g[k]));
      if (k > 0) check("t2_rvalid", 32'(rv_v), 32'(exp_g[k-1]));
      tick();
    end
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'hE006);
    check("t2_last_rvalid", 32'(rv_v), 32'b0100);
    tick();
    do_reset();

    // 3: master 3 stalled by gnt=0 for 3 cycles stays locked despite master 0
    drive(4'b1000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t3_addr_c0", slave_req.addr, 32'h4000);
    check("t3_gnt_c0", 32'(gnt_v), 32'h0);
    tick();
    for (int k = 1; k < 3; k++) begin
      drive(4'b1001, 8'd0, 1'b0, 1'b0, 32'd0);
      check("t3_addr_locked", slave_req.addr, 32'h4000);
      check("t3_gnt_locked", 32'(gnt_v), 32'h0);
      tick();
    end
    drive(4'b1001, 8'd0, 1'b1, 1'b0, 32'd0);
    check("t3_gnt_m3", 32'(gnt_v), 32'b1000);
    check("t3_addr_m3", slave_req.addr, 32'h4000);
    tick();
    drive(4'b0001, 8'd0, 1'b1, 1'b0, 32'd0);
    check("t3_gnt_m0", 32'(gnt_v), 32'b0001);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'd0);
    check("t3_rvalid_m3", 32'(rv_v), 32'b1000);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'd0);
    check("t3_rvalid_m0", 32'(rv_v), 32'b0001);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t3_busy", 32'(busy), 32'h0);
    tick();
    do_reset();

    // 4: FIFO full back-pressure; a pop does not free a slot in the same cycle
    drive(4'b0010, 8'd0, 1'b1, 1'b0, 32'd0);
    check("t4_gnt_c0", 32'(gnt_v), 32'b0010);
    tick();
    drive(4'b0010, 8'd1, 1'b1, 1'b0, 32'd0);
    check("t4_gnt_c1", 32'(gnt_v), 32'b0010);
    tick();
    drive(4'b0010, 8'd2, 1'b1, 1'b0, 32'd0);
    check("t4_full_req", 32'(slave_req.req), 32'h0);
    check("t4_full_gnt", 32'(gnt_v), 32'h0);
    check("t4_full_busy", 32'(busy), 32'h1);
    tick();
    drive(4'b0010, 8'd2, 1'b1, 1'b1, 32'd0);
    check("t4_pop_gnt", 32'(gnt_v), 32'h0);
    check("t4_pop_rvalid", 32'(rv_v), 32'b0010);
    tick();
    drive(4'b0010, 8'd2, 1'b1, 1'b0, 32'd0);
    check("t4_after_pop_gnt", 32'(gnt_v), 32'b0010);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'd0);
      check("t4_drain_rvalid", 32'(rv_v), 32'b0010);
      tick();
    end
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_err", 32'(err), 32'h0);
    tick();
    do_reset();

    // 5: spurious rvalid on an empty FIFO
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'hBAD0);
    check("t5_rvalid", 32'(rv_v), 32'h0);
    check("t5_err_before", 32'(err), 32'h0);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t5_err_set", 32'(err), 32'h1);
    tick();
    check("t5_err_sticky", 32'(err), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("t5_err_reset", 32'(err), 32'h0);
    tick();
    rst_ni = 1'b1;

    // 6: reset with two outstanding requests, arbitration restarts at master 0
    for (int k = 0; k < 2; k++) begin
      drive(4'b0001, 8'(k), 1'b1, 1'b0, 32'd0);
      check("t6_fill_gnt", 32'(gnt_v), 32'b0001);
      tick();
    end
    drive(4'b0011, 8'd0, 1'b1, 1'b0, 32'd0);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req", 32'(slave_req.req), 32'h0);
    check("t6_rst_gnt", 32'(gnt_v), 32'h0);
    drive(4'b0000, 8'd0, 1'b0, 1'b0, 32'd0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    tick();
    rst_ni = 1'b1;
    drive(4'b0011, 8'd0, 1'b1, 1'b0, 32'd0);
    check("t6_restart_gnt", 32'(gnt_v), 32'b0001);
    tick();
    drive(4'b0000, 8'd0, 1'b0, 1'b1, 32'd0);
    check("t6_rvalid", 32'(rv_v), 32'b0001);
    check("t6_err", 32'(err), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
